// File: rtl/pool_2d_stream_if.sv
// Valid/ready stream bundle carrying one packed channel vector per beat.
interface pool_2d_stream_if #(
  parameter int W = 1024
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pool_2d_stream.sv
// Streaming KER_SIZE x KER_SIZE average/max pooling over NFMAPS channels.
// Max mode is built only when POOL_2D_STREAM_MAX_EN is defined.
module pool_2d_stream #(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             mode,
  pool_2d_stream_if.slave  in_s,
  pool_2d_stream_if.master out_m
);
  localparam int WIN  = KER_SIZE * KER_SIZE;
  localparam int LW   = $clog2(WIN);
  localparam int ACCW = NBITS + LW;
  localparam int CNTW = (LW > 0) ? LW : 1;
  localparam int TW   = NBITS * NFMAPS;
  localparam bit POW2 = (WIN & (WIN - 1)) == 0;
  localparam logic signed [ACCW-1:0] BIAS = ACCW'(WIN / 2);
  localparam logic signed [ACCW-1:0] WDIV = ACCW'(WIN);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [TW-1:0]          out_act_q, out_act_d;
  logic [TW-1:0]          res_all;
  logic signed [ACCW-1:0] acc_q [NFMAPS];
  logic signed [ACCW-1:0] acc_d [NFMAPS];
  logic signed [ACCW-1:0] comb_all [NFMAPS];
  logic                   accept, first, last;

  assign accept = in_s.valid && in_ready_q && !clear;
  assign first  = cnt_q == '0;
  assign last   = cnt_q == CNTW'(WIN - 1);

`ifdef POOL_2D_STREAM_MAX_EN
  logic mode_q, mode_d, mode_eff;
  // The first beat uses the live input; later beats use the latched copy.
  assign mode_eff = first ? mode : mode_q;
  assign mode_d   = (accept && first) ? mode : mode_q;

  always_ff @(posedge clk) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  for (genvar c = 0; c < NFMAPS; c++) begin : g_ch
    logic signed [NBITS-1:0] x;
    logic signed [NBITS-1:0] avg;
    logic signed [ACCW-1:0]  xs, comb, sum_b;

    assign x  = in_s.data[c*NBITS +: NBITS];
    assign xs = ACCW'(x);

`ifdef POOL_2D_STREAM_MAX_EN
    logic signed [ACCW-1:0] mx;
    assign mx   = (xs > acc_q[c]) ? xs : acc_q[c];
    assign comb = first ? xs : (mode_eff ? mx : acc_q[c] + xs);
    assign res_all[c*NBITS +: NBITS] =
      mode_eff ? comb[NBITS-1:0] : avg;
`else
    assign comb = first ? xs : acc_q[c] + xs;
    assign res_all[c*NBITS +: NBITS] = avg;
`endif

    assign sum_b = comb + BIAS;

    if (POW2) begin : g_shift
      assign avg = NBITS'(sum_b >>> LW);
    end else begin : g_div
      // Division truncates toward zero; step negatives down to get floor.
      assign avg = NBITS'((sum_b / WDIV) -
        ((sum_b % WDIV != '0 && sum_b[ACCW-1]) ? ACCW'(1) : ACCW'(0)));
    end

    assign comb_all[c] = comb;
  end

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      for (int c = 0; c < NFMAPS; c++) begin
        acc_d[c] = comb_all[c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    if (clear) begin
      state_d     = ACCUM;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              cnt_d       = '0;
              out_act_d   = res_all;
              state_d     = HOLD;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_m.ready) begin
            state_d     = ACCUM;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
      acc_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      acc_q       <= acc_d;
    end
  end

  assign in_s.ready  = in_ready_q;
  assign out_m.valid = out_valid_q;
  assign out_m.data  = out_act_q;
endmodule

// File: tb/tb_pool_2d_stream.sv
// Directed bench for pool_2d_stream: 2x2, 3x3 and 1x1 instances,
// 8-bit activations, two channels, shared stimulus.
module tb_pool_2d_stream;
  logic        clk = 1'b0;
  logic        rst, clear, mode, in_valid, out_ready;
  logic [15:0] in_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pool_2d_stream_if #(.W(16)) k2_in ();
  pool_2d_stream_if #(.W(16)) k2_out ();
  pool_2d_stream_if #(.W(16)) k3_in ();
  pool_2d_stream_if #(.W(16)) k3_out ();
  pool_2d_stream_if #(.W(16)) k1_in ();
  pool_2d_stream_if #(.W(16)) k1_out ();

  assign k2_in.valid  = in_valid;
  assign k2_in.data   = in_data;
  assign k2_out.ready = out_ready;
  assign k3_in.valid  = in_valid;
  assign k3_in.data   = in_data;
  assign k3_out.ready = out_ready;
  assign k1_in.valid  = in_valid;
  assign k1_in.data   = in_data;
  assign k1_out.ready = out_ready;

  pool_2d_stream #(.NBITS(8), .NFMAPS(2), .KER_SIZE(2)) u_k2 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_s(k2_in), .out_m(k2_out)
  );
  pool_2d_stream #(.NBITS(8), .NFMAPS(2), .KER_SIZE(3)) u_k3 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_s(k3_in), .out_m(k3_out)
  );
  pool_2d_stream #(.NBITS(8), .NFMAPS(2), .KER_SIZE(1)) u_k1 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_s(k1_in), .out_m(k1_out)
  );

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {b, a};
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (k2_in.ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", k2_in.ready);
    end
    checks++;
    if (k2_out.valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", k2_out.valid);
    end
    checks++;
    if (k2_out.data !== 16'h0000) begin
      failures++; $display("FAIL reset_out_act got=%h exp=0000", k2_out.data);
    end
  endtask

  task automatic test_avg_pos();
    do_reset();
    send_beat(8'd50, 8'd50);
    do_reset();
    send_beat(8'd1, 8'd10);
    send_beat(8'd2, 8'd10);
    send_beat(8'd3, 8'd10);
    send_beat(8'd4, 8'd11);
    checks++;
    if (k2_out.valid !== 1'b0) begin
      failures++; $display("FAIL pos_early_valid got=%b exp=0", k2_out.valid);
    end
    idle();
    checks++;
    if (k2_out.valid !== 1'b1) begin
      failures++; $display("FAIL pos_valid got=%b exp=1", k2_out.valid);
    end
    checks++;
    if (k2_out.data !== 16'h0A03) begin
      failures++; $display("FAIL pos_act got=%h exp=0a03", k2_out.data);
    end
    checks++;
    if (k2_in.ready !== 1'b0) begin
      failures++; $display("FAIL pos_hold_ready got=%b exp=0", k2_in.ready);
    end
    drain();
    checks++;
    if (k2_out.valid !== 1'b0 || k2_in.ready !== 1'b1) begin
      failures++;
      $display("FAIL pos_drain got valid=%b ready=%b exp valid=0 ready=1",
               k2_out.valid, k2_in.ready);
    end
  endtask

  task automatic test_avg_neg();
    do_reset();
    send_beat(8'hFF, 8'h80);
    send_beat(8'hFE, 8'h80);
    send_beat(8'hFD, 8'h80);
    send_beat(8'hFC, 8'h80);
    idle();
    checks++;
    if (k2_out.valid !== 1'b1 || k2_out.data !== 16'h80FE) begin
      failures++;
      $display("FAIL neg_act got valid=%b act=%h exp valid=1 act=80fe",
               k2_out.valid, k2_out.data);
    end
  endtask

  task automatic test_max();
    logic [15:0] exp;
`ifdef POOL_2D_STREAM_MAX_EN
    exp = 16'h09FF;
`else
    exp = 16'h03FC;
`endif
    do_reset();
    mode = 1'b1;
    send_beat(8'hFB, 8'h03);
    send_beat(8'hFD, 8'h09);
    mode = 1'b0;
    send_beat(8'hF9, 8'h02);
    send_beat(8'hFF, 8'hFC);
    idle();
    checks++;
    if (k2_out.valid !== 1'b1 || k2_out.data !== exp) begin
      failures++;
      $display("FAIL max_act got valid=%b act=%h exp valid=1 act=%h",
               k2_out.valid, k2_out.data, exp);
    end
  endtask

  task automatic test_k3();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send_beat(8'(i), 8'(-i));
      if (i == 9) begin
        checks++;
        if (k3_out.valid !== 1'b0) begin
          failures++; $display("FAIL k3_early_valid got=%b exp=0", k3_out.valid);
        end
      end
    end
    idle();
    checks++;
    if (k3_out.valid !== 1'b1 || k3_out.data !== 16'hFB05) begin
      failures++;
      $display("FAIL k3_act got valid=%b act=%h exp valid=1 act=fb05",
               k3_out.valid, k3_out.data);
    end
    drain();
    for (int i = 0; i < 9; i++) send_beat(8'd0, 8'd0);
    idle();
    checks++;
    if (k3_out.valid !== 1'b1 || k3_out.data !== 16'h0000) begin
      failures++;
      $display("FAIL k3_zero got valid=%b act=%h exp valid=1 act=0000",
               k3_out.valid, k3_out.data);
    end
  endtask

  task automatic test_k1();
    do_reset();
    mode = 1'b1;
    send_beat(8'h64, 8'hF9);
    mode = 1'b0;
    idle();
    checks++;
    if (k1_out.valid !== 1'b1 || k1_out.data !== 16'hF964) begin
      failures++;
      $display("FAIL k1_max got valid=%b act=%h exp valid=1 act=f964",
               k1_out.valid, k1_out.data);
    end
    drain();
    send_beat(8'h7F, 8'h80);
    idle();
    checks++;
    if (k1_out.valid !== 1'b1 || k1_out.data !== 16'h807F) begin
      failures++;
      $display("FAIL k1_avg got valid=%b act=%h exp valid=1 act=807f",
               k1_out.valid, k1_out.data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    send_beat(8'd5, 8'd0);
    send_beat(8'd6, 8'd0);
    send_beat(8'd7, 8'd0);
    send_beat(8'd8, 8'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h3232;
      checks++;
      if (k2_out.valid !== 1'b1 || k2_out.data !== 16'h0007 ||
          k2_in.ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d got valid=%b act=%h ready=%b exp 1 0007 0",
                 i, k2_out.valid, k2_out.data, k2_in.ready);
      end
    end
    drain();
    checks++;
    if (k2_in.ready !== 1'b1 || k2_out.valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0",
               k2_in.ready, k2_out.valid);
    end
    for (int i = 0; i < 4; i++) send_beat(8'd1, 8'd2);
    idle();
    checks++;
    if (k2_out.valid !== 1'b1 || k2_out.data !== 16'h0201) begin
      failures++;
      $display("FAIL bp_next got valid=%b act=%h exp valid=1 act=0201",
               k2_out.valid, k2_out.data);
    end
  endtask

  task automatic test_clear();
    do_reset();
    send_beat(8'd9, 8'd9);
    send_beat(8'd9, 8'd9);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0909;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'd4, 8'd4);
    idle();
    checks++;
    if (k2_out.valid !== 1'b1 || k2_out.data !== 16'h0404) begin
      failures++;
      $display("FAIL clr_act got valid=%b act=%h exp valid=1 act=0404",
               k2_out.valid, k2_out.data);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (k2_out.valid !== 1'b0 || k2_in.ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_hold got valid=%b ready=%b exp valid=0 ready=1",
               k2_out.valid, k2_in.ready);
    end
    checks++;
    if (k2_out.data !== 16'h0404) begin
      failures++; $display("FAIL clr_keep got=%h exp=0404", k2_out.data);
    end
  endtask

  initial begin
    test_reset();
    test_avg_pos();
    test_avg_neg();
    test_max();
    test_k3();
    test_k1();
    test_backpressure();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pool_2d_stream.md
Name: pool_2d_stream

Overview:
- Streaming 2D pooling engine for NFMAPS feature maps processed in parallel.
- Accepts one window element per channel-vector beat and reduces KER_SIZE*KER_SIZE beats into one output vector.
- Supports average or max mode with any KER_SIZE.
- Sits between the conv/activation stage and the next layer's input buffer, using valid/ready handshakes on both sides.

Parameters:
- NBITS, 32, signed activation width per channel.
- NFMAPS, 32, number of channels processed in parallel.
- KER_SIZE, 2, pooling kernel edge; window size WIN = KER_SIZE*KER_SIZE; legal range 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clear  in  1  abort the current window, discarding its partial result
- mode  in  1  0 = average, 1 = max; sampled on the first beat of each window
- in_valid  in  1  in_act carries a window element
- in_ready  out  1  block accepts an input beat
- in_act  in  NBITS*NFMAPS  channel c at bits [(c+1)*NBITS-1 : c*NBITS], signed
- out_valid  out  1  out_act holds a completed window result
- out_ready  in  1  downstream accepts the result
- out_act  out  NBITS*NFMAPS  pooled result, same packing as in_act

Interface:
- One clock; reset is synchronous and active-high.

Behaviour:
- Reset values:
  - out_valid = 0, out_act = 0, in_ready = 1.
  - Element counter = 0, accumulators = 0, state = ACCUM, latched mode = 0.
- States:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- Accept: a beat is accepted when in_valid && in_ready at a clk edge.
- Per-channel accumulator, ACCW = NBITS + clog2(WIN) bits, signed:
  - Average mode: acc += sext(x).
  - Max mode: acc = max(acc, x), signed compare.
  - On the first beat of a window (count == 0), acc is loaded with x and the mode input is latched. Mode changes mid-window are ignored.
- Counter runs 0..WIN-1 and wraps to 0 on the WIN-th accepted beat.
  - On that beat the final result is computed from acc and the current beat combined, registered into out_act, and the state moves to HOLD.
  - Latency: out_valid rises the cycle after the last element is accepted.
- Average result: floor((sum + WIN/2) / WIN), where sum is the full ACCW value and WIN/2 uses integer division.
  - Ties round toward +inf, e.g. -2.5 -> -2 and 2.5 -> 3.
  - The result always fits in NBITS; truncate to NBITS without saturation.
  - For power-of-two WIN this reduces to an arithmetic right shift after the bias add.
- Max result: acc truncated to NBITS (lossless).
- HOLD:
  - out_act and out_valid stay stable until out_valid && out_ready.
  - The state then returns to ACCUM and in_ready rises in the next cycle, giving one bubble per window.
- clear:
  - Forces state = ACCUM, counter = 0, out_valid = 0. out_act keeps its value.
  - A beat presented in the same cycle as clear is dropped, so clear has priority over in_valid.
  - Clearing in HOLD discards the pending result.
- rst has priority over clear. rst asserted mid-window discards everything and restores the reset values.
- KER_SIZE = 1: every accepted beat passes through unchanged in both modes, with one-cycle latency.

Optional Feature:
- Macro POOL_2D_STREAM_MAX_EN.
- Defined: mode selects average or max as described above.
- Undefined:
  - Max logic and the compare tree are not synthesised.
  - The mode port exists but is ignored; the block always averages and the latched mode reads 0.

Test Plan:
- Average of a positive window: NBITS=8, NFMAPS=2, KER_SIZE=2, mode=0. Ch0 beats 1,2,3,4; ch1 beats 10,10,10,11 -> ch0 = 3 (10/4 = 2.5 rounds up), ch1 = 10; out_valid rises 1 cycle after the 4th beat.
- Average of a negative window: ch0 beats -1,-2,-3,-4 -> -2 (-2.5 rounds toward +inf); ch1 beats -128 x4 -> -128 with no overflow.
- Max mode: mode=1 (macro defined), ch0 beats -5,-3,-7,-1 -> -1. mode toggled to 0 after beat 1 -> result still max.
- KER_SIZE=3, mode=0: ch0 beats 1..9 -> 5 (floor(49/9)); the counter wraps and a second window of 9 zeros -> 0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_act stable, in_ready=0, in_valid beats not consumed. Release -> in_ready=1 the next cycle.
- clear: assert clear after 2 of 4 beats, together with a valid beat -> that beat is dropped. The next 4 beats 4,4,4,4 -> 4. clear in HOLD -> out_valid=0 the next cycle.
